// File: rtl/buffer_ram_arb.sv
// -----------------------------------------------------------------------------
// buffer_ram_arb
//
// Single-clock frame buffer for the camera pipeline. It has two ports:
//   * a dedicated VGA read port with a registered output,
//   * one shared read/write port. The clear engine, the capture writer and the
//     processing block take turns on it, in that priority order.
//
// After reset the block clears addresses 0..IMG_SIZE to BLACK, one address per
// cycle. Address IMG_SIZE is a sentinel pixel that always reads as BLACK:
// capture and processing writes at or above IMG_SIZE are discarded.
// Reads above IMG_SIZE return BLACK without touching the array.
//
// Ports
//   clk          system clock; every port is synchronous to it
//   rst_n        asynchronous active-low reset
//   cap_we       capture write strobe (never stalls)
//   cap_addr     capture write address
//   cap_data     capture pixel
//   vga_addr     VGA read address
//   vga_data     VGA pixel, 1-cycle latency, registered
//   proc_req     processing access request
//   proc_we      processing write (1) / read (0), qualified by proc_req
//   proc_addr    processing address
//   proc_wdata   processing write data
//   proc_gnt     request accepted this cycle (combinational)
//   proc_rvalid  one-cycle pulse, proc_rdata valid
//   proc_rdata   processing read data, registered
//   busy         clear sequence in progress
//   cap_drop     sticky: a capture write was discarded (cleared by reset only)
// -----------------------------------------------------------------------------
module buffer_ram_arb #(
    parameter int            AW             = 15,
    parameter int            DW             = 12,
    parameter int            IMG_W          = 160,
    parameter int            IMG_H          = 120,
    parameter logic [DW-1:0] BLACK          = '0,
    parameter bit            CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cap_we,
    input  logic [AW-1:0] cap_addr,
    input  logic [DW-1:0] cap_data,

    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,

    input  logic          proc_req,
    input  logic          proc_we,
    input  logic [AW-1:0] proc_addr,
    input  logic [DW-1:0] proc_wdata,
    output logic          proc_gnt,
    output logic          proc_rvalid,
    output logic [DW-1:0] proc_rdata,

    output logic          busy,
    output logic          cap_drop
);

    localparam int NPOS     = 2 ** AW;
    localparam int IMG_SIZE = IMG_W * IMG_H;   // must be < NPOS

    // Sentinel address, also the last address the clear engine writes.
    localparam logic [AW-1:0] SENTINEL = AW'(IMG_SIZE);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;

    logic [DW-1:0]   mem [NPOS];

    logic            in_clear;
    logic            cap_ok;
    logic            proc_rd;
    logic            proc_wr_ok;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    // -------------------------------------------------------------------------
    // Clear sequencer. READY is terminal until the next reset. Asserting reset
    // mid-clear restarts the sweep from address 0.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of the order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            busy    <= CLEAR_ON_RESET;
            clr_cnt <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == SENTINEL) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: ;  // S_READY: hold
            endcase
        end
    end

    assign in_clear = (state == S_CLEAR);

    // A capture write is accepted only outside the clear and only inside the
    // image area. This keeps the sentinel and the unused space at BLACK.
    assign cap_ok = cap_we & ~in_clear & (cap_addr < SENTINEL);

    // Any capture strobe blocks processing, even one that is then dropped.
    // This keeps the grant independent of the capture address decode.
    assign proc_gnt   = proc_req & ~in_clear & ~cap_we;
    assign proc_rd    = proc_gnt & ~proc_we;
    assign proc_wr_ok = proc_gnt & proc_we & (proc_addr < SENTINEL);

    // -------------------------------------------------------------------------
    // Shared-port write mux: clear > capture > processing.
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = BLACK;
        if (in_clear) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = BLACK;
        end else if (cap_ok) begin
            wr_en   = 1'b1;
            wr_addr = cap_addr;
            wr_data = cap_data;
        end else if (proc_wr_ok) begin
            wr_en   = 1'b1;
            wr_addr = proc_addr;
            wr_data = proc_wdata;
        end
    end

    // NOTE: the pixel array has no reset. It maps onto block RAM, and with
    // CLEAR_ON_RESET=0 its contents must survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Registered read ports. They sample the array before the same-edge write
    // lands, so a read that collides with a write returns the old data.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_data <= '0;
        end else begin
            vga_data <= (vga_addr <= SENTINEL) ? mem[vga_addr] : BLACK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_rvalid <= 1'b0;
            proc_rdata  <= '0;
        end else begin
            proc_rvalid <= proc_rd;
            if (proc_rd) begin
                proc_rdata <= (proc_addr <= SENTINEL) ? mem[proc_addr] : BLACK;
            end
        end
    end

    // Sticky drop flag. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_drop <= 1'b0;
        end else if (cap_we & ~cap_ok) begin
            cap_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_buffer_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_buffer_ram_arb
//
// Self-checking bench for buffer_ram_arb, configured as a tiny 4x2 image in a
// 32-entry memory. A behavioural model tracks the pixel contents as an array.
// It also tracks which cells hold defined data, the clear progress as a plain
// address index, and the expected registered outputs.
//
// A compare process checks every output against the model on each falling
// edge. Directed sequences add literal expectations, and a randomized phase
// follows them.
// -----------------------------------------------------------------------------
module tb_buffer_ram_arb;

    localparam int AW  = 5;
    localparam int DW  = 12;
    localparam int ISZ = 8;         // IMG_W*IMG_H
    localparam int NP  = 32;

    logic          clk;
    logic          rst_n;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          proc_req;
    logic          proc_we;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_wdata;
    logic          proc_gnt;
    logic          proc_rvalid;
    logic [DW-1:0] proc_rdata;
    logic          busy;
    logic          cap_drop;

    int vectors     = 0;
    int miscompares = 0;

    buffer_ram_arb #(
        .AW(AW), .DW(DW), .IMG_W(4), .IMG_H(2),
        .BLACK(12'h000), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
        .vga_addr(vga_addr), .vga_data(vga_data),
        .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_gnt(proc_gnt),
        .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata),
        .busy(busy), .cap_drop(cap_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [DW-1:0] mdl   [NP];
    bit            known [NP];
    bit            clearing;
    int            clr_next;
    bit            mvalid = 1'b0;
    logic [DW-1:0] e_vga, e_prd;
    bit            e_vga_k, e_prd_k, e_rv, e_drop;
    bit            g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vga = '0; e_prd = '0; e_vga_k = 1'b1; e_prd_k = 1'b1;
            e_rv = 1'b0; e_drop = 1'b0;
            clearing = 1'b1; clr_next = 0; mvalid = 1'b1;
        end else begin
            g = proc_req && !clearing && !cap_we;
            // Reads see the memory as it was before this edge.
            if (int'(vga_addr) > ISZ) begin
                e_vga = '0; e_vga_k = 1'b1;
            end else begin
                e_vga = mdl[vga_addr]; e_vga_k = known[vga_addr];
            end
            e_rv = g && !proc_we;
            if (e_rv) begin
                if (int'(proc_addr) > ISZ) begin
                    e_prd = '0; e_prd_k = 1'b1;
                end else begin
                    e_prd = mdl[proc_addr]; e_prd_k = known[proc_addr];
                end
            end
            if (clearing) begin
                mdl[clr_next] = '0; known[clr_next] = 1'b1;
                clr_next++;
                if (clr_next > ISZ) clearing = 1'b0;
                if (cap_we) e_drop = 1'b1;
            end else if (cap_we) begin
                if (int'(cap_addr) < ISZ) begin
                    mdl[cap_addr] = cap_data; known[cap_addr] = 1'b1;
                end else begin
                    e_drop = 1'b1;
                end
            end else if (g && proc_we && int'(proc_addr) < ISZ) begin
                mdl[proc_addr] = proc_wdata; known[proc_addr] = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            check("busy", busy, clearing);
            check("proc_gnt", proc_gnt, proc_req && rst_n && !clearing && !cap_we);
            check("proc_rvalid", proc_rvalid, e_rv);
            check("cap_drop", cap_drop, e_drop);
            if (e_vga_k) check("vga_data", vga_data, e_vga);
            if (e_prd_k) check("proc_rdata", proc_rdata, e_prd);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cap_we = 1'b0; proc_req = 1'b0; proc_we = 1'b0;
    endtask

    task automatic cap_write(input int a, input logic [DW-1:0] d);
        cap_we = 1'b1; cap_addr = AW'(a); cap_data = d;
        tick();
        cap_we = 1'b0;
    endtask

    // Count cycles with busy high from reset release; optional capture
    // strobes during the clear must be dropped.
    task automatic run_clear(input bit with_cap);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            cap_we   = with_cap && (n >= 5) && (n < 8);
            cap_addr = AW'(1);
            cap_data = 12'h555;
            n++;
            tick();
        end
        cap_we = 1'b0;
        check("clear_len", n, 9);
    endtask

    task automatic sweep_black();
        for (int a = 0; a <= ISZ; a++) begin
            vga_addr = AW'(a);
            tick();
            check("vga_black", vga_data, 12'h000);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NP - 1));
        return AW'($urandom_range(0, ISZ + 1));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend;
        rst_n = 1'b1; idle(); cap_addr = '0; cap_data = '0;
        vga_addr = '0; proc_addr = '0; proc_wdata = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_vga", vga_data, 0);
        check("rst_rdata", proc_rdata, 0);
        check("rst_rvalid", proc_rvalid, 0);
        check("rst_drop", cap_drop, 0);
        check("rst_busy", busy, 1);
        repeat (3) tick();
        rst_n = 1'b1;
        run_clear(1'b1);
        check("drop_in_clear", cap_drop, 1);
        sweep_black();

        // Fill the image with white, then reset mid-clear and clear again.
        for (int a = 0; a < ISZ; a++) cap_write(a, 12'hFFF);
        vga_addr = AW'(4);
        tick();
        check("fill_white", vga_data, 12'hFFF);
        rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_vga", vga_data, 0);
        check("mid_rst_rdata", proc_rdata, 0);
        check("mid_rst_rvalid", proc_rvalid, 0);
        check("mid_rst_drop", cap_drop, 0);
        check("mid_rst_busy", busy, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        run_clear(1'b0);
        check("drop_clean", cap_drop, 0);
        sweep_black();

        // Capture / VGA path and drop boundaries.
        cap_write(5, 12'hABC);
        vga_addr = AW'(5);
        tick();
        check("vga_abc", vga_data, 12'hABC);
        check("drop_still0", cap_drop, 0);
        cap_write(8, 12'h0EE);
        check("drop_sentinel", cap_drop, 1);
        cap_write(20, 12'h0DD);
        vga_addr = AW'(20); tick();
        check("vga_20", vga_data, 12'h000);
        vga_addr = AW'(8); tick();
        check("vga_sentinel", vga_data, 12'h000);

        // Same-edge collision: old data first, new data next cycle.
        cap_write(1, 12'h111);
        cap_we = 1'b1; cap_addr = AW'(1); cap_data = 12'h777; vga_addr = AW'(1);
        tick();
        check("collide_old", vga_data, 12'h111);
        cap_we = 1'b0;
        tick();
        check("collide_new", vga_data, 12'h777);

        // Arbitration: capture holds off a processing read for 3 cycles.
        cap_write(3, 12'h3C3);
        proc_req = 1'b1; proc_we = 1'b0; proc_addr = AW'(3);
        cap_we = 1'b1; cap_addr = AW'(6); cap_data = 12'h666;
        for (int i = 0; i < 3; i++) begin
            #1 check("gnt_blocked", proc_gnt, 0);
            tick();
        end
        cap_we = 1'b0;
        #1 check("gnt_free", proc_gnt, 1);
        tick();
        check("arb_rvalid", proc_rvalid, 1);
        check("arb_rdata", proc_rdata, 12'h3C3);
        proc_req = 1'b0;
        tick();
        check("rvalid_pulse", proc_rvalid, 0);

        // Processing write then read of the same address.
        proc_req = 1'b1; proc_we = 1'b1; proc_addr = AW'(2); proc_wdata = 12'h123;
        #1 check("wr_gnt", proc_gnt, 1);
        tick();
        proc_we = 1'b0;
        tick();
        check("wr_rd_valid", proc_rvalid, 1);
        check("wr_rd_data", proc_rdata, 12'h123);
        // Writes to the sentinel are ignored; reads above it return black.
        proc_we = 1'b1; proc_addr = AW'(8); proc_wdata = 12'h5A5;
        tick();
        proc_we = 1'b0;
        tick();
        check("proc_sentinel", proc_rdata, 12'h000);
        proc_addr = AW'(25);
        tick();
        check("proc_high", proc_rdata, 12'h000);
        idle();
        tick();

        // Randomized traffic; a blocked processing request is held stable.
        pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cap_we   = ($urandom_range(0, 3) == 0);
            cap_addr = rnd_addr();
            cap_data = DW'($urandom);
            vga_addr = rnd_addr();
            if (!pend) begin
                proc_req   = $urandom_range(0, 1) == 1;
                proc_we    = $urandom_range(0, 1) == 1;
                proc_addr  = rnd_addr();
                proc_wdata = DW'($urandom);
            end
            #1 pend = proc_req && !proc_gnt;
            tick();
        end
        idle();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
